serial_x_driver: RTL

- Transmit-side counterpart of the team's serial Mealy machines: serializes a parallel word onto the single-bit line `X` that those machines consume.
- Framing: one start bit, WIDTH data bits MSB first, an optional even-parity bit, then STOP_BITS stop bits.
- Handshake: valid/ready on the parallel side, so bench sequencers and upstream logic can stream frames back-to-back.
- Placement: drives `X` directly into a detector FSM that samples it on the falling edge of `CLK`.

---
 rtl/serial_x_if.sv | 43 ++++
 rtl/serial_x_driver.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/serial_x_if.sv
// ---------------------------------------------------------------------------
// serial_x_if
//   Parallel-to-serial handshake bundle between an upstream word producer
//   and serial_x_driver.
//
//   DIN    word to transmit
//   VALID  DIN is valid
//   READY  driver accepts DIN on this rising edge
//   X      serial line, idles high
//   BUSY   a frame is in progress
//   DONE   one-cycle pulse during the last stop bit
//
//   master : word producer (drives DIN/VALID, observes the rest)
//   slave  : serial_x_driver
// ---------------------------------------------------------------------------
interface serial_x_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] DIN;
  logic             VALID;
  logic             READY;
  logic             X;
  logic             BUSY;
  logic             DONE;

  modport master (
    output DIN,
    output VALID,
    input  READY,
    input  X,
    input  BUSY,
    input  DONE
  );

  modport slave (
    input  DIN,
    input  VALID,
    output READY,
    output X,
    output BUSY,
    output DONE
  );
endinterface

// File: rtl/serial_x_driver.sv
// ---------------------------------------------------------------------------
// serial_x_driver
//   Serializes a parallel word onto the single-bit line X consumed by the
//   negedge-sampling serial Mealy detectors.
//   Frame: start bit (0), WIDTH data bits MSB first, optional even-parity
//   bit, STOP_BITS stop bits (1). Frames may be streamed back-to-back.
//
// Parameters
//   WIDTH      data bits per frame, 1..16
//   STOP_BITS  stop bits per frame, 1 or 2
//
// Ports
//   CLK   in   single clock, rising-edge registers
//   RST   in   synchronous active-high reset
//   bus   slave modport of serial_x_if (DIN, VALID in; READY, X, BUSY, DONE out)
//
// Configuration
//   SERX_PARITY_EN  when defined, an even-parity bit follows the data bits.
//
// All outputs are registered; they are decoded from the next state so they
// change only just after rising edges and never combinationally from VALID.
// ---------------------------------------------------------------------------
module serial_x_driver #(
  parameter int WIDTH     = 8,
  parameter int STOP_BITS = 1
) (
  input  logic      CLK,
  input  logic      RST,
  serial_x_if.slave bus
);

  localparam int             CW        = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST_BIT  = CW'(WIDTH - 1);
  // Stop-bit counter is one bit wide: 0 for the first, 1 for the second.
  localparam logic           LAST_STOP = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
`ifdef SERX_PARITY_EN
    S_PAR   = 3'd4,
`endif
    S_STOP  = 3'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CW-1:0]     r_cnt;
  logic [CW-1:0]     w_cnt_nxt;
  logic [WIDTH-1:0]  r_shift;
  logic [WIDTH-1:0]  w_shift_nxt;
  logic              r_stop_cnt;
  logic              w_stop_cnt_nxt;

  logic              r_x;
  logic              r_ready;
  logic              r_busy;
  logic              r_done;
  logic              w_x_nxt;
  logic              w_ready_nxt;
  logic              w_busy_nxt;
  logic              w_done_nxt;
  logic              w_last_stop;

`ifdef SERX_PARITY_EN
  logic              r_par;
  logic              w_par_nxt;

  // Even parity: the returned bit makes the total count of ones even.
  function automatic logic even_parity(input logic [WIDTH-1:0] word);
    return ^word;
  endfunction
`endif

  // Next-state logic: frame sequencing, word capture and shifting.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_shift_nxt    = r_shift;
    w_stop_cnt_nxt = r_stop_cnt;
`ifdef SERX_PARITY_EN
    w_par_nxt      = r_par;
`endif
    case (r_state)
      S_IDLE: begin
        if (bus.VALID) begin
          w_shift_nxt = bus.DIN;
`ifdef SERX_PARITY_EN
          w_par_nxt   = even_parity(bus.DIN);
`endif
          w_state_nxt = S_START;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_START: begin
        w_cnt_nxt   = {CW{1'b0}};
        w_state_nxt = S_DATA;
      end
      S_DATA: begin
        // The MSB on the line is the current bit; shift only when another
        // data bit follows so the MSB always presents the next bit.
        if (r_cnt == LAST_BIT) begin
          w_stop_cnt_nxt = 1'b0;
`ifdef SERX_PARITY_EN
          w_state_nxt    = S_PAR;
`else
          w_state_nxt    = S_STOP;
`endif
        end else begin
          w_cnt_nxt   = r_cnt + CW'(1'b1);
          w_shift_nxt = r_shift << 1'b1;
        end
      end
`ifdef SERX_PARITY_EN
      S_PAR: begin
        w_stop_cnt_nxt = 1'b0;
        w_state_nxt    = S_STOP;
      end
`endif
      S_STOP: begin
        if (r_stop_cnt == LAST_STOP) begin
          // Final stop cycle doubles as an accept slot for gapless streaming.
          if (bus.VALID) begin
            w_shift_nxt = bus.DIN;
`ifdef SERX_PARITY_EN
            w_par_nxt   = even_parity(bus.DIN);
`endif
            w_state_nxt = S_START;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_stop_cnt_nxt = r_stop_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Output decode from the next state, so the registered outputs line up
  // with the state they describe.
  always_comb begin
    w_x_nxt     = 1'b1;
    w_last_stop = (w_state_nxt == S_STOP) && (w_stop_cnt_nxt == LAST_STOP);
    case (w_state_nxt)
      S_START: w_x_nxt = 1'b0;
      S_DATA:  w_x_nxt = w_shift_nxt[WIDTH-1];
`ifdef SERX_PARITY_EN
      S_PAR:   w_x_nxt = w_par_nxt;
`endif
      default: w_x_nxt = 1'b1;
    endcase
    w_busy_nxt  = (w_state_nxt != S_IDLE);
    w_ready_nxt = (w_state_nxt == S_IDLE) || w_last_stop;
    w_done_nxt  = w_last_stop;
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_cnt      <= {CW{1'b0}};
      r_shift    <= {WIDTH{1'b0}};
      r_stop_cnt <= 1'b0;
`ifdef SERX_PARITY_EN
      r_par      <= 1'b0;
`endif
      r_x        <= 1'b1;
      r_ready    <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_shift    <= w_shift_nxt;
      r_stop_cnt <= w_stop_cnt_nxt;
`ifdef SERX_PARITY_EN
      r_par      <= w_par_nxt;
`endif
      r_x        <= w_x_nxt;
      r_ready    <= w_ready_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
    end
  end

  assign bus.X     = r_x;
  assign bus.READY = r_ready;
  assign bus.BUSY  = r_busy;
  assign bus.DONE  = r_done;

endmodule
